// File: rtl/spectrum_pkg.sv
// +--------------------------------------------------------------------------+
// | spectrum_pkg: shared constants and types for the band filter/telemetry.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package spectrum_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         NBYTES_CHK        = 6;
    localparam int         NBYTES_NOCHK      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Index 0 holds band 0.
    typedef logic [3:0][7:0] band_snapshot_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// +--------------------------------------------------------------------------+
// | uart_byte_tx: 8N1 serialiser for one byte; owns baud and bit counters.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_byte_tx
    import spectrum_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_end
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_nxt;
    logic [CW-1:0] baud, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_nxt;
    logic          baud_done;

    assign baud_done = (baud == BAUD_LAST);
    // Last cycle of the stop bit: the only point where a following byte may be accepted.
    assign byte_end  = (state == STOP) && baud_done;

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_done ? '0 : baud + 1'b1;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        tx_nxt    = 1'b1;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (load) begin
                    state_nxt = START;
                    shreg_nxt = data;
                end
            end
            START: begin
                if (baud_done) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_nxt   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (load) begin
                        state_nxt = START;
                        shreg_nxt = data;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // The line level is registered from the next state so tx aligns with state.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/band_uart_tx.sv
// +--------------------------------------------------------------------------+
// | band_uart_tx: snapshots four band energies and sends them as a UART frame|
// | Option macro: SPECTRUM_TX_CHECKSUM_EN appends a checksum byte. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module band_uart_tx
    import spectrum_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic [7:0] band_energy0,
    input  logic [7:0] band_energy1,
    input  logic [7:0] band_energy2,
    input  logic [7:0] band_energy3,
    output logic       tx,
    output logic       busy,
    output logic       frame_drop
);

`ifdef SPECTRUM_TX_CHECKSUM_EN
    localparam int NBYTES = NBYTES_CHK;
`else
    localparam int NBYTES = NBYTES_NOCHK;
`endif
    localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

    band_snapshot_t in_snap, active_q, active_d, pend_q, pend_d;
    logic           pend_valid_q, pend_valid_d;
    logic [2:0]     byte_idx_q, byte_idx_d, next_idx;
    logic           drop_q, drop_d;
    logic           load, byte_end, frame_end;
    logic [7:0]     tx_byte, next_byte;

    assign in_snap   = {band_energy3, band_energy2, band_energy1, band_energy0};
    assign frame_end = byte_end && (byte_idx_q == LAST_BYTE);
    assign next_idx  = byte_idx_q + 3'd1;

`ifdef SPECTRUM_TX_CHECKSUM_EN
    logic [7:0] chk;
    // Two's-complement negation makes bytes 1..5 sum to zero modulo 256.
    assign chk = 8'd0 - (active_q[0] + active_q[1] + active_q[2] + active_q[3]);
`endif

    always_comb begin
        next_byte = 8'h00;
        case (next_idx)
            3'd1:    next_byte = active_q[0];
            3'd2:    next_byte = active_q[1];
            3'd3:    next_byte = active_q[2];
            3'd4:    next_byte = active_q[3];
`ifdef SPECTRUM_TX_CHECKSUM_EN
            3'd5:    next_byte = chk;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_comb begin
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        byte_idx_d   = byte_idx_q;
        drop_d       = 1'b0;
        load         = 1'b0;
        tx_byte      = SYNC_BYTE;
        if (!busy || frame_end) begin
            // Frame boundary: a fresh update wins over any pending snapshot.
            byte_idx_d = 3'd0;
            if (update) begin
                active_d     = in_snap;
                load         = 1'b1;
                pend_valid_d = 1'b0;
                drop_d       = pend_valid_q;
            end else if (pend_valid_q) begin
                active_d     = pend_q;
                load         = 1'b1;
                pend_valid_d = 1'b0;
            end
        end else begin
            if (byte_end) begin
                load       = 1'b1;
                tx_byte    = next_byte;
                byte_idx_d = next_idx;
            end
            if (update) begin
                pend_d       = in_snap;
                pend_valid_d = 1'b1;
                drop_d       = pend_valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            byte_idx_q   <= 3'd0;
            drop_q       <= 1'b0;
        end else begin
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            byte_idx_q   <= byte_idx_d;
            drop_q       <= drop_d;
        end
    end

    assign frame_drop = drop_q;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .data     (tx_byte),
        .tx       (tx),
        .busy     (busy),
        .byte_end (byte_end)
    );

endmodule

`default_nettype wire

// File: tb/tb_band_uart_tx.sv
// +--------------------------------------------------------------------------+
// | tb_band_uart_tx: decodes the UART line and checks frames against a model.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_band_uart_tx;

    localparam int CPB = 4;
`ifdef SPECTRUM_TX_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif
    localparam int FLEN = NB * 10 * CPB;
    localparam int H    = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       update = 1'b0;
    logic [7:0] e0 = 8'd0, e1 = 8'd0, e2 = 8'd0, e3 = 8'd0;
    logic       tx, busy, frame_drop;

    band_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .update       (update),
        .band_energy0 (e0),
        .band_energy1 (e1),
        .band_energy2 (e2),
        .band_energy3 (e3),
        .tx           (tx),
        .busy         (busy),
        .frame_drop   (frame_drop)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    // Line decoder: mid-bit sampling, aborted by reset.
    logic [7:0] got[$];
    logic       dec_active = 1'b0;
    int         dec_cnt = 0;
    int         ferr = 0;
    logic [7:0] dec_sh = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            dec_active <= 1'b0;
        end else if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active <= 1'b1;
                dec_cnt    <= 1;
            end
        end else begin
            dec_cnt <= dec_cnt + 1;
            if (dec_cnt == H && tx !== 1'b0) ferr <= ferr + 1;
            for (int i = 0; i < 8; i++)
                if (dec_cnt == CPB * (i + 1) + H) dec_sh[i] <= tx;
            if (dec_cnt == CPB * 9 + H) begin
                if (tx !== 1'b1) ferr <= ferr + 1;
                else             got.push_back(dec_sh);
            end
            if (dec_cnt == CPB * 10 - 1) dec_active <= 1'b0;
        end
    end

    int   busy_cycles = 0;
    int   busy_rises = 0;
    int   drop_cnt = 0;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        busy_cycles <= busy_cycles + ((busy === 1'b1) ? 1 : 0);
        if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises <= busy_rises + 1;
        busy_prev <= busy;
        if (frame_drop === 1'b1) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: the byte sequence of one frame from its four energies.
    logic [7:0] exp_q[$];

    task automatic add_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        int sum;
        exp_q.push_back(8'hA5);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        sum = int'(a) + int'(b) + int'(c) + int'(d);
        if (NB == 6) exp_q.push_back(8'((256 - (sum % 256)) % 256));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    endtask

    task automatic check_frames(input string tag, input int base);
        check({tag, "_nbytes"}, got.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < got.size())
                check($sformatf("%s_byte%0d", tag, k), got[base + k], exp_q[k]);
        exp_q.delete();
    endtask

    task automatic pulse(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        e0 = a; e1 = b; e2 = c; e3 = d;
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit scramble);
        int n = 0;
        while (busy !== 1'b0 && n < 4 * FLEN) begin
            @(negedge clk);
            n++;
            if (scramble) begin
                e0 = 8'($urandom); e1 = 8'($urandom);
                e2 = 8'($urandom); e3 = 8'($urandom);
            end
        end
        check({tag, "_idle_timeout"}, 32'(n < 4 * FLEN), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    int         gb, bb, rb, db;
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;

    task automatic take_bases();
        gb = got.size(); bb = busy_cycles; rb = busy_rises; db = drop_cnt;
    endtask

    task automatic randomize_sets();
        a0 = 8'($urandom); a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        c0 = 8'($urandom); c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom);
    endtask

    initial begin
        // Reset behaviour
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_drop", frame_drop, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_tx", tx, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_busy_cycles", busy_cycles, 0);

        // Single frame with directed values
        take_bases();
        pulse(8'd10, 8'd20, 8'd30, 8'd40);
        add_frame(8'd10, 8'd20, 8'd30, 8'd40);
        check("single_first_tx", tx, 0);
        check("single_first_busy", busy, 1);
        wait_idle("single", 1'b0);
        check("single_busy_len", busy_cycles - bb, FLEN);
        check("single_drops", drop_cnt - db, 0);
        check_frames("single", gb);

        // Snapshot isolation: inputs change every cycle after capture
        randomize_sets();
        take_bases();
        pulse(a0, a1, a2, a3);
        add_frame(a0, a1, a2, a3);
        wait_idle("isolation", 1'b1);
        check_frames("isolation", gb);

        // Pending snapshot follows with zero gap
        take_bases();
        pulse(8'd10, 8'd20, 8'd30, 8'd40);
        add_frame(8'd10, 8'd20, 8'd30, 8'd40);
        repeat (50) @(negedge clk);
        pulse(8'd1, 8'd2, 8'd3, 8'd4);
        add_frame(8'd1, 8'd2, 8'd3, 8'd4);
        wait_idle("pending", 1'b0);
        check("pending_busy_len", busy_cycles - bb, 2 * FLEN);
        check("pending_busy_rises", busy_rises - rb, 1);
        check("pending_drops", drop_cnt - db, 0);
        check_frames("pending", gb);

        // Overwrite of a pending snapshot
        randomize_sets();
        take_bases();
        pulse(a0, a1, a2, a3);
        add_frame(a0, a1, a2, a3);
        repeat (30) @(negedge clk);
        pulse(b0, b1, b2, b3);
        check("overwrite_no_drop_first", frame_drop, 0);
        repeat (10) @(negedge clk);
        pulse(c0, c1, c2, c3);
        add_frame(c0, c1, c2, c3);
        check("overwrite_drop_pulse", frame_drop, 1);
        wait_idle("overwrite", 1'b0);
        check("overwrite_drops", drop_cnt - db, 1);
        check("overwrite_busy_len", busy_cycles - bb, 2 * FLEN);
        check_frames("overwrite", gb);

        // Update exactly in the end-of-frame cycle with a pending snapshot
        randomize_sets();
        take_bases();
        pulse(a0, a1, a2, a3);
        add_frame(a0, a1, a2, a3);
        repeat (20) @(negedge clk);
        pulse(b0, b1, b2, b3);
        repeat (FLEN - 22) @(negedge clk);
        pulse(c0, c1, c2, c3);
        add_frame(c0, c1, c2, c3);
        check("ecycle_drop_pulse", frame_drop, 1);
        wait_idle("ecycle", 1'b0);
        check("ecycle_drops", drop_cnt - db, 1);
        check("ecycle_busy_len", busy_cycles - bb, 2 * FLEN);
        check("ecycle_busy_rises", busy_rises - rb, 1);
        check_frames("ecycle", gb);

        // Random single frames separated by random idle gaps
        for (int r = 0; r < 3; r++) begin
            randomize_sets();
            take_bases();
            pulse(a0, a1, a2, a3);
            add_frame(a0, a1, a2, a3);
            wait_idle($sformatf("rand%0d", r), 1'b0);
            check($sformatf("rand%0d_busy_len", r), busy_cycles - bb, FLEN);
            check_frames($sformatf("rand%0d", r), gb);
            repeat ($urandom_range(1, 7)) @(negedge clk);
        end

        // Reset mid-frame with a pending snapshot held
        randomize_sets();
        pulse(8'h00, a1, a2, a3);
        repeat (20) @(negedge clk);
        pulse(b0, b1, b2, b3);
        repeat (31) @(negedge clk);
        check("midrst_pre_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_async", tx, 1);
        check("midrst_busy_async", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        take_bases();
        repeat (3 * FLEN) @(negedge clk);
        check("midrst_no_resume_busy", busy_cycles - bb, 0);
        check("midrst_no_resume_bytes", got.size() - gb, 0);
        check("midrst_tx_idle", tx, 1);
        check("framing_errors", ferr, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/band_uart_tx.md
# band_uart_tx

Telemetry stage downstream of the four-band filter bank. Each time the band energies refresh, it snapshots all four 8-bit values and streams them off-chip as one framed 8N1 UART burst on a single output pin, alongside the PWM outputs. It holds one pending snapshot while a frame is in flight and reports overwritten snapshots.

## Interface
Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit; legal range ≥ 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- update  in  1  one-cycle strobe; band energies valid and newly refreshed this cycle.
- band_energy0..band_energy3  in  8 each  band energies, unsigned; sampled only when update=1.
- tx  out  1  UART line; idle high.
- busy  out  1  high while a frame is on the line.
- frame_drop  out  1  one-cycle pulse when a pending snapshot is overwritten or discarded.

## Operation
- Frame: SYNC_BYTE, e0, e1, e2, e3, then CHK when the checksum is compiled in. That gives 6 bytes with CHK, 5 without (NBYTES).
- CHK = (256 − ((e0+e1+e2+e3) mod 256)) mod 256, so bytes 1..5 sum to 0 mod 256.
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- Registers:
  - active snapshot (4×8);
  - pending snapshot (4×8) plus pend_valid;
  - baud counter ($clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT−1);
  - bit index 0..7;
  - byte index 0..NBYTES−1.
- FSM states IDLE, START, DATA, STOP:
  - IDLE → START on update, or on pend_valid. The snapshot is loaded into the active buffer.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after 8 bits.
  - STOP → START (next byte) when the byte index < NBYTES−1.
  - On the last byte, STOP exits to START (new frame) if update is high or pend_valid is set; otherwise to IDLE.
- Snapshot capture is the only sampling point. Input changes after the update cycle never affect a frame in flight.
- update while busy (not in the end-of-frame cycle):
  - the values go to the pending buffer and pend_valid is set;
  - if pend_valid was already 1, the old pending is overwritten and frame_drop pulses.
- End-of-frame cycle E is the last cycle of the last stop bit:
  - update at E: its values feed the next frame directly. Any pend_valid content is discarded, pend_valid is cleared, and frame_drop pulses.
  - no update at E but pend_valid: the pending buffer is loaded and pend_valid is cleared.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the state goes to IDLE, and pend_valid is cleared. No partial frame resumes.

## Timing
- Reset values: tx=1, busy=0, frame_drop=0, pend_valid=0, FSM=IDLE, all counters 0.
- tx, busy and frame_drop are registered outputs.
- update sampled at edge N (IDLE): tx=0 and busy=1 from cycle N+1, which is the start bit of SYNC_BYTE.
- Frame length: NBYTES×10×CLKS_PER_BIT cycles. busy stays high for exactly that many cycles per frame.
- Back-to-back frames: the start bit of the next frame follows cycle E with zero gap, and busy stays high continuously.
- frame_drop is high in the cycle after the overwriting/discarding update.

## Configuration
- SPECTRUM_TX_CHECKSUM_EN defined: NBYTES=6 and the CHK byte is appended; the checksum adder is instantiated.
- SPECTRUM_TX_CHECKSUM_EN undefined: NBYTES=5 and the frame ends after e3; no checksum logic.

## Structure
- Shared package spectrum_pkg holds:
  - the default SYNC_BYTE constant;
  - the NBYTES constants for both configurations;
  - the FSM state enum typedef;
  - a 4×8 band-snapshot typedef, also usable by the filter bank.
- Sub-module uart_byte_tx is the natural split: it serialises one byte with start/stop and owns the baud and bit counters.
- The top of band_uart_tx does snapshot buffering, pending/drop logic, byte sequencing and CHK.

## Test plan
All scenarios use CLKS_PER_BIT=4, SPECTRUM_TX_CHECKSUM_EN defined unless stated.
- Reset: hold rst_n=0, then release → tx=1, busy=0, frame_drop=0, and they stay so with no update.
- Single frame: update with e=10,20,30,40 → bytes A5,0A,14,1E,28,9C decoded from tx. busy high for exactly 240 cycles; tx=0 first at N+1.
- Snapshot isolation: change band_energy inputs every cycle after update → decoded frame is still 0A,14,1E,28.
- Pending: second update (e=1,2,3,4) mid-frame → second frame A5,01,02,03,04,F6 follows with zero idle gap. busy high for 480 contiguous cycles; no frame_drop.
- Overwrite and E-cycle: two updates mid-frame → one frame_drop pulse and only the later values are sent. An update at E with pend_valid set → frame_drop pulses, and the E-cycle values are sent.
- Checksum disabled, plus reset mid-frame:
  - macro undefined → 5-byte frames, 200 cycles of busy;
  - rst_n pulsed low during DATA → tx=1 immediately, and no resumed frame.
